// File: rtl/hazard_mul_scheduler.sv
// RAW-hazard bubble insertion and shift-add multiplier sequencing
// for the 5-stage core, all on the single CLK domain.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   id_*              decode-stage instruction (sources, use flags, MUL)
//   ex_/mem_/wb_we,rd in-flight register-file writers
//   stall_if          hold PC and IF/ID
//   bubble_ex         load NOP into ID/EX
//   hold_ex           hold ID/EX contents
//   bubble_mem        load NOP into EX/MEM
//   mul_start         one-cycle multiplier start pulse
//   mul_busy          multiply in progress
//   stall_cycles      saturating count of stall_if cycles
module hazard_mul_scheduler #(
    parameter int MUL_CYCLES = 34,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_mul,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              hold_ex,
    output logic              bubble_mem,
    output logic              mul_start,
    output logic              mul_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          first_q;

    logic rs_hit;
    logic rt_hit;
    logic haz;
    logic last;
    logic issue;

    // A WB match still stalls: the regfile write and the decode read
    // in the same cycle are not ordered. Register 0 never hazards.
    assign rs_hit = id_uses_rs & (id_rs != '0) &
                    ((ex_we  & (ex_rd  == id_rs)) |
                     (mem_we & (mem_rd == id_rs)) |
                     (wb_we  & (wb_rd  == id_rs)));

    assign rt_hit = id_uses_rt & (id_rt != '0) &
                    ((ex_we  & (ex_rd  == id_rt)) |
                     (mem_we & (mem_rd == id_rt)) |
                     (wb_we  & (wb_rd  == id_rt)));

    assign haz = id_valid & (rs_hit | rt_hit);

    // Release cycle: the product is latched into EX/MEM at this edge.
    assign last = (state == MUL_RUN) && (cnt == '0);

    // Hazard wins over MUL, so a dependent MUL waits in decode.
    assign issue = (state == IDLE) & ~haz & id_valid & id_is_mul;

    always_comb begin
        stall_if   = 1'b0;
        bubble_ex  = 1'b0;
        hold_ex    = 1'b0;
        bubble_mem = 1'b0;
        mul_start  = 1'b0;
        mul_busy   = 1'b0;
        if (!RST) begin
            if (state == MUL_RUN) begin
                mul_busy   = 1'b1;
                mul_start  = first_q;
                stall_if   = ~last;
                hold_ex    = ~last;
                bubble_mem = ~last;
            end else if (haz) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            first_q      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (stall_if && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            first_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= MUL_RUN;
                        cnt     <= CNT_INIT;
                        first_q <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_mul_scheduler.sv
// Randomized and directed check of hazard_mul_scheduler against a
// cycle-level reference model (two instances: MUL_CYCLES=34 and 1).
module tb_hazard_mul_scheduler;

    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_is_mul;
    logic          ex_we;
    logic [AW-1:0] ex_rd;
    logic          mem_we;
    logic [AW-1:0] mem_rd;
    logic          wb_we;
    logic [AW-1:0] wb_rd;

    logic        a_stall, a_bex, a_hold, a_bmem, a_start, a_busy;
    logic [15:0] a_sc;
    logic        b_stall, b_bex, b_hold, b_bmem, b_start, b_busy;
    logic [5:0]  b_sc;

    hazard_mul_scheduler #(
        .MUL_CYCLES(34), .REG_AW(AW), .CNT_W(16)
    ) u_a (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_mul(id_is_mul),
        .ex_we(ex_we), .ex_rd(ex_rd),
        .mem_we(mem_we), .mem_rd(mem_rd),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .stall_if(a_stall), .bubble_ex(a_bex), .hold_ex(a_hold),
        .bubble_mem(a_bmem), .mul_start(a_start), .mul_busy(a_busy),
        .stall_cycles(a_sc)
    );

    hazard_mul_scheduler #(
        .MUL_CYCLES(1), .REG_AW(AW), .CNT_W(6)
    ) u_b (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_mul(id_is_mul),
        .ex_we(ex_we), .ex_rd(ex_rd),
        .mem_we(mem_we), .mem_rd(mem_rd),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .stall_if(b_stall), .bubble_ex(b_bex), .hold_ex(b_hold),
        .bubble_mem(b_bmem), .mul_start(b_start), .mul_busy(b_busy),
        .stall_cycles(b_sc)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: k = 0 idle, else 1..M position in MUL.
    int mc[2] = '{34, 1};
    int cm[2] = '{65535, 63};
    int k[2]  = '{0, 0};
    int sc[2] = '{0, 0};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit reads_inflight(input bit use_r,
                                          input logic [AW-1:0] r);
        logic [AW-1:0] rd[3];
        bit            we[3];
        rd = '{ex_rd, mem_rd, wb_rd};
        we = '{ex_we, mem_we, wb_we};
        if (!use_r || r == 0) return 0;
        foreach (rd[j])
            if (we[j] && rd[j] == r) return 1;
        return 0;
    endfunction

    task automatic cycle();
        bit haz;
        bit e_st, e_bx, e_hd, e_bm, e_ms, e_bz, rel;
        logic [31:0] g[7];
        string nm;
        @(negedge CLK);
        haz = id_valid && (reads_inflight(id_uses_rs, id_rs) ||
                           reads_inflight(id_uses_rt, id_rt));
        for (int i = 0; i < 2; i++) begin
            nm = (i == 0) ? "m34" : "m1";
            if (i == 0)
                g = '{a_stall, a_bex, a_hold, a_bmem,
                      a_start, a_busy, 32'(a_sc)};
            else
                g = '{b_stall, b_bex, b_hold, b_bmem,
                      b_start, b_busy, 32'(b_sc)};
            {e_st, e_bx, e_hd, e_bm, e_ms, e_bz, rel} = '0;
            if (RST) begin
                rel = 0;
            end else if (k[i] != 0) begin
                rel  = (k[i] == mc[i]);
                e_ms = (k[i] == 1);
                e_st = !rel;
                e_hd = !rel;
                e_bm = !rel;
                e_bz = 1;
            end else begin
                e_st = haz;
                e_bx = haz;
            end
            chk({nm, ".stall_if"},   g[0], 32'(e_st));
            chk({nm, ".bubble_ex"},  g[1], 32'(e_bx));
            chk({nm, ".hold_ex"},    g[2], 32'(e_hd));
            chk({nm, ".bubble_mem"}, g[3], 32'(e_bm));
            chk({nm, ".mul_start"},  g[4], 32'(e_ms));
            if (!rel)
                chk({nm, ".mul_busy"}, g[5], 32'(e_bz));
            chk({nm, ".stall_cycles"}, g[6], 32'(RST ? 0 : sc[i]));
            if (RST) begin
                k[i]  = 0;
                sc[i] = 0;
            end else begin
                if (e_st && sc[i] < cm[i]) sc[i]++;
                if (k[i] != 0)
                    k[i] = (k[i] == mc[i]) ? 0 : k[i] + 1;
                else if (!haz && id_valid && id_is_mul)
                    k[i] = 1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        id_valid = 0; id_is_mul = 0;
        id_uses_rs = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0;
        ex_we = 0; mem_we = 0; wb_we = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int base;

    initial begin
        RST = 1;
        quiet();
        #1;
        run(2);
        RST = 0;
        run(1);

        // independent stream
        id_valid = 1; id_uses_rs = 1; id_uses_rt = 1;
        id_rs = 1; id_rt = 2;
        ex_we = 1; ex_rd = 3; mem_we = 1; mem_rd = 4;
        wb_we = 1; wb_rd = 5;
        run(5);
        chk("indep.sc", 32'(a_sc), 0);

        // dependency moving through EX, MEM, WB
        quiet();
        id_valid = 1; id_uses_rs = 1; id_rs = 7;
        ex_we = 1; ex_rd = 7;
        cycle();
        ex_we = 0; mem_we = 1; mem_rd = 7;
        cycle();
        mem_we = 0; wb_we = 1; wb_rd = 7;
        cycle();
        wb_we = 0;
        cycle();
        chk("raw3.sc", 32'(a_sc), 3);

        // r0 and unused rt never stall
        quiet();
        id_valid = 1; id_uses_rs = 1; id_rs = 0;
        ex_we = 1; ex_rd = 0;
        id_rt = 9; id_uses_rt = 0; mem_we = 1; mem_rd = 9;
        run(2);
        chk("r0.sc", 32'(a_sc), 3);

        // clean MUL
        quiet();
        base = a_sc;
        id_valid = 1; id_is_mul = 1; id_rs = 1; id_uses_rs = 1;
        cycle();
        quiet();
        run(36);
        chk("mul.sc", 32'(a_sc), 32'(base + 33));

        // MUL held back by a MEM hazard
        id_valid = 1; id_is_mul = 1; id_uses_rs = 1; id_rs = 6;
        mem_we = 1; mem_rd = 6;
        run(2);
        mem_we = 0;
        cycle();
        quiet();
        run(36);

        // reset in the middle of MUL_RUN, then a fresh MUL
        id_valid = 1; id_is_mul = 1;
        cycle();
        quiet();
        run(10);
        RST = 1;
        cycle();
        RST = 0;
        id_valid = 1; id_is_mul = 1;
        cycle();
        quiet();
        run(36);

        // random traffic
        for (int n = 0; n < 2500; n++) begin
            RST        = ($urandom_range(0, 199) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_is_mul  = ($urandom_range(0, 9) == 0);
            id_uses_rs = $urandom_range(0, 1);
            id_uses_rt = $urandom_range(0, 1);
            id_rs      = AW'($urandom_range(0, 3));
            id_rt      = AW'($urandom_range(0, 3));
            ex_we      = $urandom_range(0, 1);
            mem_we     = $urandom_range(0, 1);
            wb_we      = $urandom_range(0, 1);
            ex_rd      = AW'($urandom_range(0, 5));
            mem_rd     = AW'($urandom_range(0, 5));
            wb_rd      = AW'($urandom_range(0, 5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
